// File: rtl/tx_arbiter.sv
// Round-robin byte arbiter feeding one UART transmitter, with per-frame locking and a busy-handshake watchdog.
// Accepts a byte in IDLE with a same-cycle req_ready pulse; no new byte is taken until the transmitter drops tx_busy.
module tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int LOCK_TMO  = 4096,
  parameter int BUSY_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_dat,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              lock_active,
  output logic              err_busy
);

  localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
  localparam int BW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TMO - 1);
  localparam logic [BW-1:0] WAIT_LAST = BW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic [7:0]    dat_q, dat_d;
  logic [1:0]    grant_q, grant_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          arm_q, arm_d;

  logic          rr_vld;
  logic [1:0]    rr_idx;
  logic [1:0]    win;
  logic          accept;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = grant_q;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_vld && req_valid[grant_q + 2'(k)]) begin
        rr_vld = 1'b1;
        rr_idx = grant_q + 2'(k);
      end
    end
  end

  // arm_q blocks acceptance for the first cycle after reset so req_ready is low throughout reset.
  assign arm_d     = 1'b1;
  assign win       = lock_q ? grant_q : rr_idx;
  assign accept    = arm_q && (state_q == IDLE) && (lock_q ? req_valid[grant_q] : rr_vld);
  assign req_ready = accept ? (NREQ'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dat_d   = req_data[{win, 3'b000} +: 8];
          grant_d = win;
          lock_d  = ~req_last[win];
          tmo_d   = '0;
          state_d = START;
        end else if (lock_q && arm_q) begin
          // Owner is silent: drop the lock once it has idled LOCK_TMO cycles.
          if (tmo_q == TMO_LAST) begin
            lock_d = 1'b0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      START: begin
        wait_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + BW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      grant_q <= 2'd3;
      lock_q  <= 1'b0;
      tmo_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
    end
  end

  assign tx_dat      = dat_q;
  assign tx_start    = (state_q == START);
  assign grant_id    = grant_q;
  assign lock_active = lock_q;
  assign err_busy    = err_q;

endmodule
